hilo_seq: RTL and testbench
===========================

# hilo_seq

Multi-cycle sequencer for the HI/LO path of the 54-instruction MIPS CPU. It accepts HI/LO-class instructions (MTHI, MTLO, MULT, MULTU, DIV, DIVU, MFHI, MFLO) from the controller. It generates the 8-bit select codes consumed by the HI, LO and register-file write-back multiplexers, together with the HI/LO write enables. It also sequences the multiplier latency and the divider start/done handshake, and holds the CPU with `stall` until results are committed.

## Interface
- `MULT_LAT`, default 3: multiplier result latency in cycles (≥1).
- `DIV_TIMEOUT`, default 64: maximum cycles to wait for `div_done` before aborting (≥2).

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `op_valid`  in  1  HI/LO-class instruction presented this cycle.
- `op`  in  3  0 MTHI, 1 MTLO, 2 MULT, 3 MULTU, 4 DIV, 5 DIVU, 6 MFHI, 7 MFLO.
- `div_by_zero`  in  1  divisor (rt) is zero; sampled at acceptance.
- `div_done`  in  1  divider result valid, one-cycle pulse.
- `mux_hi`  out  8  HI source select: 0 Rs, 1 DIV, 2 DIVU, 3 MULT, 4 MULTU.
- `mux_lo`  out  8  LO source select, same encoding as `mux_hi`.
- `hi_we`, `lo_we`  out  1  HI/LO register write enables.
- `rf_mux`  out  8  register-file write-data select: 5 HI, 6 LO, 0 otherwise.
- `rf_hilo_we`  out  1  register-file write for MFHI/MFLO.
- `div_start`  out  1  one-cycle divider start pulse.
- `div_signed`  out  1  valid with `div_start`: 1 DIV, 0 DIVU.
- `stall`  out  1  freeze PC and instruction; high while an operation is in flight.
- `div_err`  out  1  one-cycle pulse on divider timeout.

## Operation
- FSM states: IDLE, MUL_WAIT, DIV_WAIT.
- An op is accepted when `op_valid` is high in IDLE. `op_valid` is ignored in all other states.
- Op fields are latched at acceptance: op kind and signedness.
- A 16-bit counter `cnt` is shared by MUL_WAIT (countdown) and DIV_WAIT (count-up).
- All outputs are Mealy combinational from state, `cnt` and inputs. Outputs not asserted default to 0, and select codes default to 0.

Per op, in IDLE on acceptance:
- **MTHI / MTLO**: `hi_we` / `lo_we` = 1 with select 0 in the same cycle. State stays IDLE; `stall` = 0.
- **MFHI / MFLO**: `rf_mux` = 5 / 6 and `rf_hilo_we` = 1 in the same cycle. `stall` = 0.
- **MULT / MULTU**: `stall` = 1. Next state is MUL_WAIT with `cnt` = MULT_LAT−1.
  - In MUL_WAIT, `cnt` decrements each cycle while `cnt` ≠ 0.
  - At `cnt` = 0: `hi_we` = `lo_we` = 1, select = 3 (MULT) or 4 (MULTU), `stall` = 0, next state IDLE.
- **DIV / DIVU with `div_by_zero` = 1**: no start and no write; HI/LO are left unchanged. `stall` = 0.
- **DIV / DIVU otherwise**: `div_start` = 1 and `div_signed` set in the same cycle. `stall` = 1. Next state is DIV_WAIT with `cnt` = 1.
  - In DIV_WAIT, when `div_done` = 1: `hi_we` = `lo_we` = 1, select = 1 (DIV) or 2 (DIVU), `stall` = 0, next state IDLE.
  - Else if `cnt` = DIV_TIMEOUT: `div_err` = 1, no write, `stall` = 0, next state IDLE.
  - Otherwise `cnt` increments and `stall` = 1.

Boundary conditions:
- `div_done` in IDLE or MUL_WAIT is ignored; no write occurs.
- `div_done` coinciding with the timeout cycle: done has priority, and the results are written with no error.
- MULT_LAT = 1: exactly one stall cycle (the acceptance cycle). The write happens in the next cycle.
- Reset mid-operation: state returns to IDLE, `cnt` = 0, and the pending write is dropped.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `stall`, `hi_we`, `lo_we`, `rf_hilo_we`, `div_start`, `div_signed`, `div_err` = 0.
  - `mux_hi`, `mux_lo`, `rf_mux` = 0.
- MTHI/MTLO/MFHI/MFLO and DIV with zero divisor: 0 stall cycles; effect occurs in the acceptance cycle.
- MULT/MULTU: `stall` is high for exactly MULT_LAT cycles. The HI/LO write occurs in cycle MULT_LAT after acceptance, the first cycle with `stall` = 0.
- DIV/DIVU: `stall` is high from acceptance until the cycle before `div_done`. The write occurs in the `div_done` cycle.
- A new op can be accepted in the cycle immediately after the write cycle.
- Maximum wait in DIV_WAIT: DIV_TIMEOUT cycles.

## Test plan
- **Reset**: `rst` pulse, then `op_valid` = 0 for 3 cycles. Expect all outputs 0.
- **MTHI**: accepted at cycle 0. Expect `hi_we` = 1, `mux_hi` = 0, `stall` = 0 at cycle 0. Then MFLO at cycle 1: expect `rf_mux` = 6 and `rf_hilo_we` = 1 at cycle 1.
- **MULTU, MULT_LAT = 3**: accepted at cycle 0. Expect `stall` = 1 at cycles 0–2. At cycle 3 expect `hi_we` = `lo_we` = 1, `mux_hi` = `mux_lo` = 4, `stall` = 0. An `op_valid` held high at cycles 1–2 is not accepted.
- **DIV**: accepted at cycle 0 with `div_by_zero` = 0. Expect `div_start` = 1 and `div_signed` = 1 at cycle 0. With `div_done` at cycle 5: `stall` = 1 at cycles 0–4; at cycle 5 write with select 1.
  - Repeat with `div_by_zero` = 1: expect no `div_start` and no write.
- **DIVU timeout, DIV_TIMEOUT = 4**: no `div_done`. Expect `div_err` = 1 at cycle 4 with no write and `stall` = 0.
  - Rerun with `div_done` at cycle 4: expect a write with select 2 and `div_err` = 0.
- **Reset mid-MULT**: assert `rst` at cycle 1 of MUL_WAIT, then feed a stray `div_done`. Expect `stall` = 0 and no `hi_we`/`lo_we`.

Source files
------------

// File: rtl/hilo_seq.sv
// hilo_seq: multi-cycle sequencer for the CPU's HI/LO datapath.
//
// Accepts HI/LO-class ops (MTHI, MTLO, MULT, MULTU, DIV, DIVU, MFHI, MFLO) and
// drives the select codes and write enables for the HI, LO and register-file
// write-back muxes. It times the multiplier latency and handshakes with the divider.
// While an op is in flight, stall holds the PC and instruction.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   op_valid, op          HI/LO-class op presented this cycle and its 3-bit code
//   div_by_zero           divisor is zero, sampled when the op is accepted
//   div_done              one-cycle divider result-valid pulse
//   mux_hi, mux_lo        HI/LO source select (0 Rs, 1 DIV, 2 DIVU, 3 MULT, 4 MULTU)
//   hi_we, lo_we          HI/LO write enables
//   rf_mux, rf_hilo_we    register-file write-data select (5 HI, 6 LO) and enable
//   div_start, div_signed divider start pulse and signedness
//   stall                 op in flight
//   div_err               one-cycle pulse when the divider times out
module hilo_seq #(
  parameter int unsigned MULT_LAT    = 3,
  parameter int unsigned DIV_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] op,
  input  logic       div_by_zero,
  input  logic       div_done,
  output logic [7:0] mux_hi,
  output logic [7:0] mux_lo,
  output logic       hi_we,
  output logic       lo_we,
  output logic [7:0] rf_mux,
  output logic       rf_hilo_we,
  output logic       div_start,
  output logic       div_signed,
  output logic       stall,
  output logic       div_err
);

  localparam logic [2:0] OpMthi  = 3'd0;
  localparam logic [2:0] OpMtlo  = 3'd1;
  localparam logic [2:0] OpMult  = 3'd2;
  localparam logic [2:0] OpMultu = 3'd3;
  localparam logic [2:0] OpDiv   = 3'd4;
  localparam logic [2:0] OpDivu  = 3'd5;
  localparam logic [2:0] OpMfhi  = 3'd6;
  localparam logic [2:0] OpMflo  = 3'd7;

  localparam logic [7:0] SelRs    = 8'd0;
  localparam logic [7:0] SelDiv   = 8'd1;
  localparam logic [7:0] SelDivu  = 8'd2;
  localparam logic [7:0] SelMult  = 8'd3;
  localparam logic [7:0] SelMultu = 8'd4;
  localparam logic [7:0] RfSelHi  = 8'd5;
  localparam logic [7:0] RfSelLo  = 8'd6;

  localparam logic [15:0] MulInit = 16'(MULT_LAT - 1);
  localparam logic [15:0] DivMax  = 16'(DIV_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StMulWait, StDivWait} state_e;

  state_e      state_q;
  logic [15:0] cnt_q;     // countdown in StMulWait, count-up in StDivWait
  logic        signed_q;  // latched signedness: MULT vs MULTU, DIV vs DIVU

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 16'd0;
      signed_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (op_valid) begin
            if (op == OpMult || op == OpMultu) begin
              state_q  <= StMulWait;
              cnt_q    <= MulInit;
              signed_q <= (op == OpMult);
            end else if ((op == OpDiv || op == OpDivu) && !div_by_zero) begin
              state_q  <= StDivWait;
              cnt_q    <= 16'd1;
              signed_q <= (op == OpDiv);
            end
          end
        end
        StMulWait: begin
          if (cnt_q == 16'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        StDivWait: begin
          // div_done beats the timeout when both land in the same cycle
          if (div_done || cnt_q == DivMax) begin
            state_q <= StIdle;
            cnt_q   <= 16'd0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    mux_hi     = SelRs;
    mux_lo     = SelRs;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    rf_mux     = 8'd0;
    rf_hilo_we = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    stall      = 1'b0;
    div_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          case (op)
            OpMthi:  hi_we = 1'b1;
            OpMtlo:  lo_we = 1'b1;
            OpMfhi: begin
              rf_mux     = RfSelHi;
              rf_hilo_we = 1'b1;
            end
            OpMflo: begin
              rf_mux     = RfSelLo;
              rf_hilo_we = 1'b1;
            end
            OpMult, OpMultu: stall = 1'b1;
            OpDiv, OpDivu: begin
              // A zero divisor is dropped: no start, HI/LO untouched
              if (!div_by_zero) begin
                div_start  = 1'b1;
                div_signed = (op == OpDiv);
                stall      = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      StMulWait: begin
        if (cnt_q == 16'd0) begin
          hi_we  = 1'b1;
          lo_we  = 1'b1;
          mux_hi = signed_q ? SelMult : SelMultu;
          mux_lo = signed_q ? SelMult : SelMultu;
        end else begin
          stall = 1'b1;
        end
      end
      StDivWait: begin
        if (div_done) begin
          hi_we  = 1'b1;
          lo_we  = 1'b1;
          mux_hi = signed_q ? SelDiv : SelDivu;
          mux_lo = signed_q ? SelDiv : SelDivu;
        end else if (cnt_q == DivMax) begin
          div_err = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hilo_seq.sv
// tb_hilo_seq: directed bench for hilo_seq. Instance a uses the default latencies
// (MULT_LAT 3, DIV_TIMEOUT 64). Instance b uses MULT_LAT 1 and DIV_TIMEOUT 4.
// sel routes stimulus to one instance and holds the other's inputs at zero.
module tb_hilo_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       op_valid;
  logic [2:0] op;
  logic       div_by_zero;
  logic       div_done;

  logic [7:0] a_mux_hi, a_mux_lo, a_rf_mux, b_mux_hi, b_mux_lo, b_rf_mux;
  logic a_hi_we, a_lo_we, a_rf_hilo_we, a_div_start, a_div_signed, a_stall, a_div_err;
  logic b_hi_we, b_lo_we, b_rf_hilo_we, b_div_start, b_div_signed, b_stall, b_div_err;

  always #5 clk = ~clk;

  hilo_seq #(.MULT_LAT(3), .DIV_TIMEOUT(64)) dut_a (
    .clk(clk), .rst(rst),
    .op_valid(op_valid & ~sel), .op(sel ? 3'd0 : op),
    .div_by_zero(div_by_zero & ~sel), .div_done(div_done & ~sel),
    .mux_hi(a_mux_hi), .mux_lo(a_mux_lo), .hi_we(a_hi_we), .lo_we(a_lo_we),
    .rf_mux(a_rf_mux), .rf_hilo_we(a_rf_hilo_we), .div_start(a_div_start),
    .div_signed(a_div_signed), .stall(a_stall), .div_err(a_div_err)
  );

  hilo_seq #(.MULT_LAT(1), .DIV_TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst),
    .op_valid(op_valid & sel), .op(sel ? op : 3'd0),
    .div_by_zero(div_by_zero & sel), .div_done(div_done & sel),
    .mux_hi(b_mux_hi), .mux_lo(b_mux_lo), .hi_we(b_hi_we), .lo_we(b_lo_we),
    .rf_mux(b_rf_mux), .rf_hilo_we(b_rf_hilo_we), .div_start(b_div_start),
    .div_signed(b_div_signed), .stall(b_stall), .div_err(b_div_err)
  );

  // {mux_hi, mux_lo, rf_mux, hi_we, lo_we, rf_hilo_we, div_start, div_signed, stall, div_err}
  typedef struct {
    string       tag;
    logic [30:0] exp;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  localparam logic [30:0] Z = 31'd0;
  localparam logic [30:0] S = 31'd2;  // stall only

  function automatic logic [30:0] ev(input logic [7:0] mh, input logic [7:0] ml,
                                     input logic [7:0] rm, input logic hw, input logic lw,
                                     input logic rw, input logic ds, input logic dg,
                                     input logic st, input logic er);
    return {mh, ml, rm, hw, lw, rw, ds, dg, st, er};
  endfunction

  function automatic logic [30:0] observed();
    if (sel)
      return {b_mux_hi, b_mux_lo, b_rf_mux, b_hi_we, b_lo_we, b_rf_hilo_we, b_div_start,
              b_div_signed, b_stall, b_div_err};
    return {a_mux_hi, a_mux_lo, a_rf_mux, a_hi_we, a_lo_we, a_rf_hilo_we, a_div_start,
            a_div_signed, a_stall, a_div_err};
  endfunction

  // Drive one cycle of inputs at the falling edge, queue the expectation, then
  // sample the combinational outputs 1 ns later, well before the rising edge.
  task automatic step(input string tag, input logic ov, input logic [2:0] o,
                      input logic dbz, input logic dd, input logic r,
                      input logic [30:0] exp);
    exp_t e;
    logic [30:0] obs;
    @(negedge clk);
    op_valid    = ov;
    op          = o;
    div_by_zero = dbz;
    div_done    = dd;
    rst         = r;
    sb.push_back('{tag: tag, exp: exp});
    #1;
    e   = sb.pop_front();
    obs = observed();
    nvec++;
    assert (obs === e.exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; op_valid = 1'b0; op = 3'd0;
    div_by_zero = 1'b0; div_done = 1'b0;

    // Reset
    step("rst_hold", 0, 3'd0, 0, 0, 1, Z);
    for (int i = 0; i < 3; i++) step("rst_idle", 0, 3'd0, 0, 0, 0, Z);

    // Single-cycle moves
    step("mthi", 1, 3'd0, 0, 0, 0, ev(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("mflo", 1, 3'd7, 0, 0, 0, ev(0, 0, 6, 0, 0, 1, 0, 0, 0, 0));
    step("mtlo", 1, 3'd1, 0, 0, 0, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    step("mfhi", 1, 3'd6, 0, 0, 0, ev(0, 0, 5, 0, 0, 1, 0, 0, 0, 0));
    step("done_in_idle", 0, 3'd0, 0, 1, 0, Z);

    // MULTU, latency 3, op_valid held during the wait is ignored
    step("multu_c0", 1, 3'd3, 0, 0, 0, S);
    step("multu_c1", 1, 3'd0, 0, 0, 0, S);
    step("multu_c2", 1, 3'd1, 0, 0, 0, S);
    step("multu_c3", 0, 3'd0, 0, 0, 0, ev(4, 4, 0, 1, 1, 0, 0, 0, 0, 0));
    step("after_multu", 1, 3'd6, 0, 0, 0, ev(0, 0, 5, 0, 0, 1, 0, 0, 0, 0));

    // MULT with a stray div_done during the wait
    step("mult_c0", 1, 3'd2, 0, 0, 0, S);
    step("mult_c1_done", 0, 3'd0, 0, 1, 0, S);
    step("mult_c2", 0, 3'd0, 0, 0, 0, S);
    step("mult_c3", 0, 3'd0, 0, 0, 0, ev(3, 3, 0, 1, 1, 0, 0, 0, 0, 0));

    // DIV, done at cycle 5
    step("div_c0", 1, 3'd4, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    for (int i = 1; i <= 4; i++) step("div_wait", 0, 3'd0, 0, 0, 0, S);
    step("div_c5", 0, 3'd0, 0, 1, 0, ev(1, 1, 0, 1, 1, 0, 0, 0, 0, 0));

    // DIV by zero: nothing happens, next op accepted at once
    step("div_dbz", 1, 3'd4, 1, 0, 0, Z);
    step("after_dbz", 1, 3'd1, 0, 0, 0, ev(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    // DIVU with a quick done
    step("divu_c0", 1, 3'd5, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    step("divu_c1", 0, 3'd0, 0, 1, 0, ev(2, 2, 0, 1, 1, 0, 0, 0, 0, 0));

    // Reset in the middle of a MULT drops the pending write
    step("rmult_c0", 1, 3'd2, 0, 0, 0, S);
    step("rmult_c1", 0, 3'd0, 0, 0, 0, S);
    step("rmult_rst", 0, 3'd0, 0, 0, 1, Z);
    step("rmult_stray", 0, 3'd0, 0, 1, 0, Z);
    step("rmult_idle", 0, 3'd0, 0, 0, 0, Z);

    // Instance b: DIV_TIMEOUT 4, MULT_LAT 1
    sel = 1'b1;
    step("b_idle", 0, 3'd0, 0, 0, 0, Z);
    step("to_c0", 1, 3'd5, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int i = 1; i <= 3; i++) step("to_wait", 0, 3'd0, 0, 0, 0, S);
    step("to_c4_err", 0, 3'd0, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("to_c5", 0, 3'd0, 0, 0, 0, Z);

    step("tod_c0", 1, 3'd5, 0, 0, 0, ev(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int i = 1; i <= 3; i++) step("tod_wait", 0, 3'd0, 0, 0, 0, S);
    step("tod_c4_done", 0, 3'd0, 0, 1, 0, ev(2, 2, 0, 1, 1, 0, 0, 0, 0, 0));

    step("lat1_c0", 1, 3'd3, 0, 0, 0, S);
    step("lat1_c1", 0, 3'd0, 0, 0, 0, ev(4, 4, 0, 1, 1, 0, 0, 0, 0, 0));
    step("lat1m_c0", 1, 3'd2, 0, 0, 0, S);
    step("lat1m_c1", 0, 3'd0, 0, 0, 0, ev(3, 3, 0, 1, 1, 0, 0, 0, 0, 0));
    step("b_end", 0, 3'd0, 0, 0, 0, Z);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
